// File: rtl/uart_rx_oversampled_pkg.sv
// uart_pkg: receiver state encoding, default line timing and tick divider helpers
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam int DEF_CLK_FREQ = 100_000_000;
  localparam int DEF_BAUD_RATE = 115200;
  localparam int DEF_OVERSAMPLE = 16;
  function automatic int tick_div(input int clk_freq, input int baud_rate, input int oversample);
    return clk_freq / (baud_rate * oversample);
  endfunction
  function automatic int tick_width(input int clk_freq, input int baud_rate, input int oversample);
    int d;
    d = tick_div(clk_freq, baud_rate, oversample);
    return d > 1 ? $clog2(d) : 1;
  endfunction
endpackage

// File: rtl/uart_rx_oversampled_if.sv
// uart_rx_oversampled_if: serial input and received-byte outputs; master drives rx, slave is the receiver
interface uart_rx_oversampled_if;
  logic rx;
  logic [7:0] data_out;
  logic data_valid;
  logic frame_error;
  logic busy;
  modport master(output rx, input data_out, data_valid, frame_error, busy);
  modport slave(input rx, output data_out, data_valid, frame_error, busy);
endinterface

// File: rtl/uart_rx_oversampled_baud_tick_gen.sv
// baud_tick_gen: one-clk oversampling tick every CLK_FREQ/(BAUD_RATE*OVERSAMPLE) clocks; ports clk, reset, clear (phase realign), tick
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int BAUD_RATE = DEF_BAUD_RATE,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);
  localparam int DIV = tick_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int W = tick_width(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  logic [W-1:0] cnt;
  assign tick = cnt == W'(DIV - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= clear || tick ? '0 : cnt + W'(1);
endmodule

// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled: 8N1 UART receiver, 16x oversampled mid-bit sampling; ports clk, reset, bus (rx in; data_out, data_valid, frame_error, busy out)
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int BAUD_RATE = DEF_BAUD_RATE,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input logic clk,
  input logic reset,
  uart_rx_oversampled_if.slave bus
);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] HALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] LAST = SW'(OVERSAMPLE - 1);
  logic rx_meta, rx_sync, rx_prev, tick, start_edge;
  logic [SW-1:0] s;
  logic [2:0] idx;
  logic [7:0] shift;
  state_t state;
  assign start_edge = state == IDLE && rx_prev && !rx_sync;
  baud_tick_gen #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .OVERSAMPLE(OVERSAMPLE)) u_tick (
    .clk(clk), .reset(reset), .clear(start_edge), .tick(tick)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) {rx_meta, rx_sync, rx_prev} <= 3'b111;
    else {rx_meta, rx_sync, rx_prev} <= {bus.rx, rx_meta, rx_sync};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      s <= '0;
      idx <= '0;
      shift <= '0;
      bus.data_out <= '0;
      bus.data_valid <= 1'b0;
      bus.frame_error <= 1'b0;
      bus.busy <= 1'b0;
    end else begin
      bus.data_valid <= 1'b0;
      bus.frame_error <= 1'b0;
      case (state)
        IDLE: if (start_edge) begin
          state <= START;
          s <= '0;
          bus.busy <= 1'b1;
        end
        START: if (tick) begin
          if (s == HALF) begin
            s <= '0;
            idx <= '0;
            state <= rx_sync ? IDLE : DATA;
            bus.busy <= !rx_sync;
          end else s <= s + SW'(1);
        end
        DATA: if (tick) begin
          if (s == LAST) begin
            s <= '0;
            shift[idx] <= rx_sync;
            idx <= idx + 3'd1;
            if (idx == 3'd7) state <= STOP;
          end else s <= s + SW'(1);
        end
        STOP: if (tick) begin
          if (s == LAST) begin
            s <= '0;
            state <= IDLE;
            bus.busy <= 1'b0;
            bus.data_valid <= rx_sync;
            bus.frame_error <= !rx_sync;
            if (rx_sync) bus.data_out <= shift;
          end else s <= s + SW'(1);
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb_uart_rx_oversampled: table-driven and scoreboarded checks of the UART receiver
`timescale 1ns/1ps
module tb_uart_rx_oversampled;
  localparam int BIT = 96;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] last_good = 8'h00;
  typedef struct {
    logic err;
    logic [7:0] data;
    int t0;
  } exp_t;
  typedef struct {
    logic [7:0] data;
    int bitc;
    int gap;
    logic exp_err;
    logic [7:0] exp_data;
  } vec_t;
  exp_t q[$];
  vec_t tbl[5];
  uart_rx_oversampled_if bus();
  uart_rx_oversampled #(.CLK_FREQ(11_059_200), .BAUD_RATE(115200), .OVERSAMPLE(16)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic send(input logic [7:0] d, input int bitc, input logic stop, input logic exp_err, input logic [7:0] exp_data);
    exp_t e;
    e.err = exp_err;
    e.data = exp_data;
    e.t0 = cyc;
    q.push_back(e);
    bus.rx = 1'b0;
    repeat (bitc) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx = d[i];
      repeat (bitc) @(negedge clk);
    end
    bus.rx = stop;
    repeat (bitc) @(negedge clk);
  endtask
  always @(negedge clk)
    if (reset) last_good = 8'h00;
    else if (bus.data_valid || bus.frame_error) begin
      check("pulse_exclusive", 32'(bus.data_valid & bus.frame_error), 0);
      if (q.size() == 0) check("unexpected_pulse", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        check("pulse_kind_frame_error", 32'(bus.frame_error), 32'(e.err));
        check("busy_falls_with_pulse", 32'(bus.busy), 0);
        check("data_out", 32'(bus.data_out), e.err ? 32'(last_good) : 32'(e.data));
        check("latency_in_window", 32'((cyc - e.t0) inside {[905:925]}), 1);
        if (!e.err) last_good = e.data;
      end
    end
  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    tbl[0] = '{8'h55, BIT, 200, 1'b0, 8'h55};
    tbl[1] = '{8'hA5, BIT, 0, 1'b0, 8'hA5};
    tbl[2] = '{8'h3C, BIT, 200, 1'b0, 8'h3C};
    tbl[3] = '{8'h96, 98, 200, 1'b0, 8'h96};
    tbl[4] = '{8'h96, 94, 200, 1'b0, 8'h96};
    bus.rx = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_data_out", 32'(bus.data_out), 0);
    check("reset_data_valid", 32'(bus.data_valid), 0);
    check("reset_frame_error", 32'(bus.frame_error), 0);
    check("reset_busy", 32'(bus.busy), 0);
    reset = 1'b0;
    repeat (120) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      send(tbl[i].data, tbl[i].bitc, 1'b1, tbl[i].exp_err, tbl[i].exp_data);
      repeat (tbl[i].gap) @(negedge clk);
    end
    bus.rx = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch_busy_high", 32'(bus.busy), 1);
    repeat (20) @(negedge clk);
    bus.rx = 1'b1;
    repeat (200) @(negedge clk);
    check("glitch_busy_low", 32'(bus.busy), 0);
    check("glitch_data_out_kept", 32'(bus.data_out), 32'h96);
    send(8'h81, BIT, 1'b0, 1'b1, 8'h00);
    repeat (125) @(negedge clk);
    check("break_no_start", 32'(bus.busy), 0);
    bus.rx = 1'b1;
    repeat (200) @(negedge clk);
    send(8'h7E, BIT, 1'b1, 1'b0, 8'h7E);
    repeat (200) @(negedge clk);
    bus.rx = 1'b0;
    repeat (BIT * 4 + BIT / 2) @(negedge clk);
    check("abort_busy_mid_frame", 32'(bus.busy), 1);
    bus.rx = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("in_reset_data_out", 32'(bus.data_out), 0);
    check("in_reset_busy", 32'(bus.busy), 0);
    check("in_reset_data_valid", 32'(bus.data_valid), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("post_reset_data_out", 32'(bus.data_out), 0);
    check("post_reset_busy", 32'(bus.busy), 0);
    repeat (1000) @(negedge clk);
    send(8'hC3, BIT, 1'b1, 1'b0, 8'hC3);
    repeat (200) @(negedge clk);
    check("all_expected_pulses_seen", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
